fetch_ctrl: RTL and testbench
=============================

# fetch_ctrl

- Issues instruction addresses to the single-cycle-latency instruction fetch stage.
- Owns the program counter and presents fetched instruction/PC pairs to decode through a one-entry skid buffer.
- Handles decode back-pressure without losing or duplicating instructions, and squashes wrong-path fetches on a jump redirect from execute.
- Sits between execute/decode control and the fetch stage.

## Interface

- `RESET_VECTOR`, default `16'h0000`: PC after reset. Bit 0 is ignored and treated as 0.
- `clk`  in  1: system clock; all state updates on the rising edge.
- `rst`  in  1: reset. One clock; reset is synchronous and active-high.
- `stall`  in  1: decode cannot accept `out_*` this cycle.
- `redirect_valid`  in  1: execute requests a PC change (jump).
- `redirect_addr`  in  16: jump target; bit 0 forced to 0.
- `fetch_en`  out  1: issue a fetch this cycle.
- `fetch_addr`  out  16: address of the fetch issued this cycle.
- `fetch_ready`  in  1: fetch result valid; asserted exactly one cycle after `fetch_en`.
- `fetch_instr`  in  16: fetched instruction.
- `fetch_pc`  in  16: address of the fetched instruction.
- `out_valid`  out  1: `out_instr`/`out_pc` valid for decode.
- `out_instr`  out  16: instruction to decode.
- `out_pc`  out  16: PC of `out_instr`.
- `issue_count`  out  16: number of fetches issued; wraps.
- `squash_count`  out  16: number of valid fetch results discarded; wraps.

## Operation

- **State:** `pc[15:0]`, `buf_valid`, `buf_instr`, `buf_pc`, `issue_count`, `squash_count`.
- **Fetch issue:**
  - `fetch_en = !rst && (redirect_valid || !stall)`.
  - `fetch_addr = redirect_valid ? {redirect_addr[15:1],1'b0} : pc`.
  - When issuing, `pc <= fetch_addr + 2`, modulo 2^16, so `FFFE` is followed by `0000`.
- **Output selection:**
  - `out_valid = !rst && !redirect_valid && (buf_valid || fetch_ready)`.
  - `out_*` come from the buffer when `buf_valid`, otherwise from `fetch_*`.
- **Consume:** decode consumes the output when `out_valid && !stall`.
- **Buffer update, in priority order:**
  - `rst` or `redirect_valid`: `buf_valid <= 0`. If the buffer held an entry or `fetch_ready` was high, `squash_count` increments by the number discarded (0–2).
  - `stall` with `fetch_ready` and `!buf_valid`: capture `fetch_*` into the buffer.
  - `!stall` with `buf_valid` and `fetch_ready`: cannot occur (see invariant). If it does, the buffer takes `fetch_*`.
  - `!stall` with `buf_valid`: `buf_valid <= 0`.
- **Invariant:** `buf_valid` implies `!fetch_ready`. The verifier asserts this every cycle. This invariant is what makes depth 1 sufficient.
- **Simultaneous events:**
  - Redirect outranks stall.
  - A redirect issued while `stall=1` produces a result that lands in the now-empty buffer.
- **`issue_count`:** increments on every cycle with `fetch_en=1`.

## Timing

- **Reset values:** `fetch_en=0`, `out_valid=0`, `buf_valid=0`, `pc=RESET_VECTOR`, both counters 0. `out_instr`/`out_pc` are don't-care while `out_valid=0`.
- **Reset mid-operation:** discards the buffer and any arriving result. No fetch is issued during `rst`, so no stale `fetch_ready` appears after release.
- **Start-up:** first `fetch_en` is in the first cycle with `rst=0`; its instruction appears on `out_*` one cycle later.
- **Steady state:** one instruction per cycle with no bubbles. A stall release does not insert a bubble.
- **Redirect latency:** redirect at cycle t. The target's instruction is on `out_*` at t+1, unless stalled. `out_valid=0` at t.
- **Combinational paths:**
  - `stall` and `redirect_valid` to `fetch_en`/`fetch_addr`/`out_valid`.
  - `fetch_*` to `out_*`.
  - All other outputs are registered.

## Structure

- Shared package holds:
  - `PC_W=16`, `INSTR_W=16`.
  - `PC_STEP=2`.
  - NOP encoding `16'hF000`, for benches.
- One natural sub-module, `skid_buf1`: the one-entry buffer with capture/drain/flush controls. PC, issue logic and counters stay in `fetch_ctrl`.

## Test plan

1. **Reset release:** `RESET_VECTOR=0`, `stall=0`.
   - `fetch_addr` is 0000, 0002, 0004 … on consecutive cycles.
   - `out_pc` is 0000 one cycle after the first issue.
   - `issue_count` increments each cycle.
2. **Single-cycle stall:** `stall=1` for one cycle while 0004 is arriving.
   - 0004 is buffered and no fetch is issued that cycle.
   - After release: `out_pc` is 0004, then 0006. No duplicate, no loss.
3. **Redirect:** `redirect_addr=0x0013` while 0006 is in flight.
   - `fetch_addr=0012`, `out_valid=0` that cycle.
   - Next cycle `out_pc=0012`, then 0014.
   - `squash_count=1`.
4. **Redirect during a stall with the buffer full:**
   - Buffer is flushed.
   - Target 0040 is buffered next cycle and output on stall release.
   - `squash_count` increments by the number of entries discarded.
5. **Wrap:** `RESET_VECTOR=FFFC` gives `fetch_addr` FFFC, FFFE, 0000, 0002.
6. **Reset mid-stream with the buffer full:**
   - `out_valid=0` and the buffer is empty.
   - Fetching restarts at `RESET_VECTOR`.
   - Counters return to 0.

Source files
------------

// File: rtl/fetch_ctrl_pkg.sv
// Shared widths, constants and the fetch entry type for the fetch controller.
package fetch_ctrl_pkg;
    localparam int PC_W    = 16;
    localparam int INSTR_W = 16;

    localparam logic [PC_W-1:0]    PC_STEP   = 16'd2;
    localparam logic [INSTR_W-1:0] NOP_INSTR = 16'hF000;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [PC_W-1:0]    pc;
    } fetch_entry_t;

    // Instructions are halfword aligned; bit 0 of any address is dropped.
    function automatic logic [PC_W-1:0] align_pc(input logic [PC_W-1:0] addr);
        return {addr[PC_W-1:1], 1'b0};
    endfunction
endpackage

// File: rtl/skid_buf1.sv
// One-entry skid buffer holding a fetched instruction/PC pair.
// Priority: flush, then capture, then drain.
module skid_buf1
    import fetch_ctrl_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         capture,
    input  logic         drain,
    input  fetch_entry_t din,
    output logic         valid,
    output fetch_entry_t dout
);
    logic         valid_q, valid_d;
    fetch_entry_t data_q, data_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (capture) begin
            valid_d = 1'b1;
            data_d  = din;
        end else if (drain) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
        end else begin
            valid_q <= valid_d;
        end
        data_q <= data_d;
    end

    assign valid = valid_q;
    assign dout  = data_q;
endmodule

// File: rtl/fetch_ctrl.sv
// Fetch controller: owns the PC, issues fetches, and presents results to
// decode through a one-entry skid buffer, squashing wrong-path results on jumps.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_VECTOR = 16'h0000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               redirect_valid,
    input  logic [PC_W-1:0]    redirect_addr,
    output logic               fetch_en,
    output logic [PC_W-1:0]    fetch_addr,
    input  logic               fetch_ready,
    input  logic [INSTR_W-1:0] fetch_instr,
    input  logic [PC_W-1:0]    fetch_pc,
    output logic               out_valid,
    output logic [INSTR_W-1:0] out_instr,
    output logic [PC_W-1:0]    out_pc,
    output logic [15:0]        issue_count,
    output logic [15:0]        squash_count
);
    logic [PC_W-1:0] pc_q, pc_d;
    logic [15:0]     issue_count_q, issue_count_d;
    logic [15:0]     squash_count_q, squash_count_d;

    logic            buf_valid;
    logic            buf_capture;
    logic            buf_drain;
    fetch_entry_t    buf_entry;
    fetch_entry_t    fetch_entry;

    assign fetch_entry = '{instr: fetch_instr, pc: fetch_pc};

    always_comb begin
        fetch_en   = !rst && (redirect_valid || !stall);
        fetch_addr = redirect_valid ? align_pc(redirect_addr) : pc_q;

        out_valid  = !rst && !redirect_valid && (buf_valid || fetch_ready);
        out_instr  = buf_valid ? buf_entry.instr : fetch_instr;
        out_pc     = buf_valid ? buf_entry.pc    : fetch_pc;

        pc_d = pc_q;
        if (fetch_en) begin
            pc_d = fetch_addr + PC_STEP;
        end

        issue_count_d = issue_count_q + {15'd0, fetch_en};

        // A jump throws away whatever is buffered plus whatever is landing now.
        squash_count_d = squash_count_q;
        if (redirect_valid) begin
            squash_count_d = squash_count_q + {15'd0, buf_valid} + {15'd0, fetch_ready};
        end

        // Capture when decode is stalled and the buffer is free; the non-stalled
        // case with both sources valid should be impossible but keeps the newest.
        buf_capture = fetch_ready && (stall ? !buf_valid : buf_valid);
        buf_drain   = !stall && buf_valid;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q           <= align_pc(RESET_VECTOR);
            issue_count_q  <= 16'd0;
            squash_count_q <= 16'd0;
        end else begin
            pc_q           <= pc_d;
            issue_count_q  <= issue_count_d;
            squash_count_q <= squash_count_d;
        end
    end

    skid_buf1 u_buf (
        .clk     (clk),
        .rst     (rst),
        .flush   (redirect_valid),
        .capture (buf_capture),
        .drain   (buf_drain),
        .din     (fetch_entry),
        .valid   (buf_valid),
        .dout    (buf_entry)
    );

    assign issue_count  = issue_count_q;
    assign squash_count = squash_count_q;
endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed scenarios with literal expectations, then
// random stall/redirect/reset traffic against a queue-based reference model.
module tb_fetch_ctrl;
    import fetch_ctrl_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [15:0] redirect_addr = 16'h0;

    logic        fetch_en, fetch_ready;
    logic [15:0] fetch_addr, fetch_instr, fetch_pc;
    logic        out_valid;
    logic [15:0] out_instr, out_pc, issue_count, squash_count;

    logic        w_fetch_en, w_fetch_ready, w_out_valid;
    logic [15:0] w_fetch_addr, w_fetch_instr, w_fetch_pc;
    logic [15:0] w_out_instr, w_out_pc, w_issue_count, w_squash_count;

    fetch_ctrl dut (
        .clk(clk), .rst(rst), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
        .fetch_en(fetch_en), .fetch_addr(fetch_addr),
        .fetch_ready(fetch_ready), .fetch_instr(fetch_instr), .fetch_pc(fetch_pc),
        .out_valid(out_valid), .out_instr(out_instr), .out_pc(out_pc),
        .issue_count(issue_count), .squash_count(squash_count)
    );

    fetch_ctrl #(.RESET_VECTOR(16'hFFFC)) dut_w (
        .clk(clk), .rst(rst), .stall(1'b0),
        .redirect_valid(1'b0), .redirect_addr(16'h0000),
        .fetch_en(w_fetch_en), .fetch_addr(w_fetch_addr),
        .fetch_ready(w_fetch_ready), .fetch_instr(w_fetch_instr), .fetch_pc(w_fetch_pc),
        .out_valid(w_out_valid), .out_instr(w_out_instr), .out_pc(w_out_pc),
        .issue_count(w_issue_count), .squash_count(w_squash_count)
    );

    function automatic logic [15:0] instr_of(input logic [15:0] a);
        return a ^ 16'h5A3C;
    endfunction

    // Single-cycle-latency instruction memory for both instances.
    always @(posedge clk) begin
        fetch_ready   <= fetch_en;
        fetch_pc      <= fetch_addr;
        fetch_instr   <= fetch_en ? instr_of(fetch_addr) : NOP_INSTR;
        w_fetch_ready <= w_fetch_en;
        w_fetch_pc    <= w_fetch_addr;
        w_fetch_instr <= w_fetch_en ? instr_of(w_fetch_addr) : NOP_INSTR;
    end

    // ---------------- reference model / scoreboard ----------------
    int checks = 0;
    int errors = 0;

    logic [15:0] m_pc = 16'h0000;
    logic [15:0] m_issue = 16'h0;
    logic [15:0] m_squash = 16'h0;
    bit          m_inflight = 1'b0;
    logic [15:0] m_inflight_pc = 16'h0;
    logic [15:0] exp_q[$];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One cycle: drive inputs after the falling edge, compare, advance the model.
    task automatic step(input bit r, input bit s, input bit rv, input logic [15:0] ra);
        logic [15:0] avail[$];
        bit          exp_en;
        bit          exp_ov;
        logic [15:0] exp_addr;
        @(negedge clk);
        rst = r;
        stall = s;
        redirect_valid = rv;
        redirect_addr = ra;
        #1;
        exp_en   = !r && (rv || !s);
        exp_addr = rv ? {ra[15:1], 1'b0} : m_pc;
        avail = exp_q;
        if (m_inflight) avail.push_back(m_inflight_pc);
        exp_ov = !r && !rv && (avail.size() > 0);

        check("fetch_en", {15'd0, fetch_en}, {15'd0, exp_en});
        if (exp_en) check("fetch_addr", fetch_addr, exp_addr);
        check("out_valid", {15'd0, out_valid}, {15'd0, exp_ov});
        if (exp_ov) begin
            check("out_pc", out_pc, avail[0]);
            check("out_instr", out_instr, instr_of(avail[0]));
        end
        check("issue_count", issue_count, m_issue);
        check("squash_count", squash_count, m_squash);
        if (!r) check("buf_invariant", {15'd0, dut.buf_valid && fetch_ready}, 16'h0);

        if (r) begin
            exp_q = {};
            m_pc = 16'h0000;
            m_issue = 16'h0;
            m_squash = 16'h0;
        end else begin
            if (exp_en) begin
                m_issue = m_issue + 16'd1;
                m_pc = exp_addr + 16'd2;
            end
            if (rv) begin
                m_squash = m_squash + 16'(avail.size());
                exp_q = {};
            end else begin
                if (exp_ov && !s) void'(avail.pop_front());
                exp_q = avail;
            end
        end
        m_inflight = exp_en;
        m_inflight_pc = exp_addr;
    endtask

    // ---------------- directed scenarios ----------------
    bit          d_stall[15] = '{0,0,0,1,0,0,0,1,1,1,0,0,1,1,0};
    bit          d_redir[15] = '{0,0,0,0,0,1,0,0,1,0,0,0,0,0,0};
    bit          d_rst[15]   = '{0,0,0,0,0,0,0,0,0,0,0,0,0,1,0};
    logic [15:0] d_addr[15]  = '{16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0013, 16'h0, 16'h0,
                                 16'h0040, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};

    initial begin
        rst = 1'b1;
        repeat (2) @(posedge clk);
        step(1'b1, 1'b0, 1'b0, 16'h0);

        for (int i = 0; i < 15; i++) begin
            step(d_rst[i], d_stall[i], d_redir[i], d_addr[i]);
            case (i)
                0: begin
                    check("lit_c0_addr", fetch_addr, 16'h0000);
                    check("lit_c0_ov", {15'd0, out_valid}, 16'h0);
                    check("lit_c0_issue", issue_count, 16'h0);
                    check("lit_wrap0", w_fetch_addr, 16'hFFFC);
                end
                1: begin
                    check("lit_c1_addr", fetch_addr, 16'h0002);
                    check("lit_c1_pc", out_pc, 16'h0000);
                    check("lit_c1_issue", issue_count, 16'h1);
                    check("lit_wrap1", w_fetch_addr, 16'hFFFE);
                end
                2: begin
                    check("lit_c2_addr", fetch_addr, 16'h0004);
                    check("lit_c2_pc", out_pc, 16'h0002);
                    check("lit_wrap2", w_fetch_addr, 16'h0000);
                end
                3: begin
                    check("lit_stall_en", {15'd0, fetch_en}, 16'h0);
                    check("lit_stall_pc", out_pc, 16'h0004);
                    check("lit_wrap3", w_fetch_addr, 16'h0002);
                end
                4: begin
                    check("lit_release_pc", out_pc, 16'h0004);
                    check("lit_release_addr", fetch_addr, 16'h0006);
                end
                5: begin
                    check("lit_redir_addr", fetch_addr, 16'h0012);
                    check("lit_redir_ov", {15'd0, out_valid}, 16'h0);
                end
                6: begin
                    check("lit_target_pc", out_pc, 16'h0012);
                    check("lit_squash1", squash_count, 16'h1);
                end
                7: check("lit_c7_pc", out_pc, 16'h0014);
                8: begin
                    check("lit_sredir_addr", fetch_addr, 16'h0040);
                    check("lit_sredir_ov", {15'd0, out_valid}, 16'h0);
                end
                9: begin
                    check("lit_sredir_pc", out_pc, 16'h0040);
                    check("lit_squash2", squash_count, 16'h2);
                end
                10: begin
                    check("lit_c10_pc", out_pc, 16'h0040);
                    check("lit_c10_addr", fetch_addr, 16'h0042);
                end
                11: check("lit_c11_pc", out_pc, 16'h0042);
                13: check("lit_rst_ov", {15'd0, out_valid}, 16'h0);
                14: begin
                    check("lit_restart_ov", {15'd0, out_valid}, 16'h0);
                    check("lit_restart_addr", fetch_addr, 16'h0000);
                    check("lit_restart_issue", issue_count, 16'h0);
                    check("lit_restart_squash", squash_count, 16'h0);
                end
                default: ;
            endcase
        end

        // ---------------- random traffic ----------------
        for (int n = 0; n < 4000; n++) begin
            bit          r, s, rv;
            logic [15:0] ra;
            r  = ($urandom_range(0, 99) == 0);
            s  = ($urandom_range(0, 99) < 30);
            rv = ($urandom_range(0, 99) < 10);
            ra = ($urandom_range(0, 3) == 0) ? (16'hFFF0 | 16'($urandom_range(0, 15)))
                                             : 16'($urandom);
            step(r, s, rv, ra);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
